// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared definitions for the UART command engine: command codes,
//            fixed reply words, FSM state encoding and err_flags bit indices.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  // Command byte values
  localparam logic [7:0] C_CMD_ADDR     = 8'h01;
  localparam logic [7:0] C_CMD_LOAD     = 8'h02;
  localparam logic [7:0] C_CMD_WRITE    = 8'h03;
  localparam logic [7:0] C_CMD_READ     = 8'h04;
  localparam logic [7:0] C_CMD_READ_REQ = 8'h05;
  localparam logic [7:0] C_CMD_COUNT    = 8'h06;
  localparam logic [7:0] C_CMD_CONST    = 8'h07;

  // Fixed reply words
  localparam logic [31:0] C_REPLY_BAD    = 32'hFFFF_FFFF;
  localparam logic [31:0] C_REPLY_MEM_TO = 32'hFFFF_FFFE;
  localparam logic [31:0] C_REPLY_WR_OK  = 32'h0000_0003;

  // err_flags bit positions
  localparam int C_ERR_RX_TO  = 0;
  localparam int C_ERR_MEM_TO = 1;
  localparam int C_ERR_DROP   = 2;

  // Command engine FSM encoding
  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_DECODE        = 3'd1,
    S_MEM_WAIT_IDLE = 3'd2,
    S_MEM_REQ       = 3'd3,
    S_MEM_WAIT_DONE = 3'd4,
    S_TX_START      = 3'd5,
    S_TX_WAIT_LOW   = 3'd6,
    S_TX_WAIT_HIGH  = 3'd7
  } state_t;

  // True for commands that need a HyperRAM transaction
  function automatic logic is_mem_cmd(input logic [7:0] cmd);
    return (cmd == C_CMD_WRITE) || (cmd == C_CMD_READ_REQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_engine_frame_asm.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_asm
// Purpose  : Collects 5 received bytes into a 40-bit frame (command byte
//            first), pulses frame_valid one cycle after the 5th byte, and
//            discards a partial frame after RX_TIMEOUT idle clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_asm #(
  parameter int RX_TIMEOUT = 1200000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_rcv,
  input  logic [7:0]  rx_data,
  output logic        frame_valid,
  output logic [39:0] frame_data,
  output logic        rx_timeout
);

  localparam int TW = (RX_TIMEOUT > 2) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [TW-1:0] C_TIMER_LAST = TW'(RX_TIMEOUT - 1);

  logic [2:0]    r_byte_cnt;
  logic [39:0]   r_shift;
  logic [TW-1:0] r_timer;
  logic          r_frame_valid;
  logic          r_rx_to;

  logic w_last_byte;
  logic w_expire;

  // The 5th byte closes the frame; a byte in the expiry cycle counts as activity
  assign w_last_byte = rx_rcv && (r_byte_cnt == 3'd4);
  assign w_expire    = !rx_rcv && (r_byte_cnt != 3'd0) && (r_timer == C_TIMER_LAST);

  assign frame_valid = r_frame_valid;
  assign frame_data  = r_shift;
  assign rx_timeout  = r_rx_to;

  // Shift each received byte in from the right so the command ends up on top
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= 40'd0;
    end else if (rx_rcv) begin
      r_shift <= {r_shift[31:0], rx_data};
    end
  end

  // Byte counter and inter-byte idle timer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_cnt <= 3'd0;
      r_timer    <= '0;
    end else if (rx_rcv) begin
      r_timer    <= '0;
      r_byte_cnt <= w_last_byte ? 3'd0 : r_byte_cnt + 3'd1;
    end else if (w_expire) begin
      r_timer    <= '0;
      r_byte_cnt <= 3'd0;
    end else if (r_byte_cnt != 3'd0) begin
      r_timer    <= r_timer + 1'b1;
    end else begin
      r_timer    <= '0;
    end
  end

  // Single-cycle status strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_valid <= 1'b0;
      r_rx_to       <= 1'b0;
    end else begin
      r_frame_valid <= w_last_byte;
      r_rx_to       <= w_expire;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_engine
// Purpose  : Executes 5-byte UART command frames as register updates or
//            HyperRAM read/write requests and returns one 4-byte big-endian
//            reply per accepted frame through the uart_tx handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int          RX_TIMEOUT  = 1200000,
  parameter int          MEM_TIMEOUT = 4096,
  parameter logic [31:0] CONST_VAL   = 32'd259
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_rcv,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_d,
  output logic        mem_wr_req,
  output logic        mem_rd_req,
  input  logic        mem_busy,
  input  logic [31:0] mem_rd_d,
  input  logic        mem_rd_rdy,
  output logic [4:0]  dbg_addr,
  output logic [2:0]  err_flags
);

  localparam int MW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [MW-1:0] C_MEM_LAST = MW'(MEM_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [7:0]    r_cmd;
  logic [31:0]   r_arg;
  logic [31:0]   r_reply;
  logic [1:0]    r_tx_idx;
  logic [MW-1:0] r_mem_cnt;
  logic          r_busy_seen;
  logic [31:0]   r_rd_latch;
  logic [31:0]   r_count;

  logic          w_frame_valid;
  logic [39:0]   w_frame_data;
  logic          w_rx_timeout;
  logic          w_mem_expired;
  logic          w_mem_done;

  uart_frame_asm #(
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_frame_asm (
    .clk         (clk),
    .rstn        (rstn),
    .rx_rcv      (rx_rcv),
    .rx_data     (rx_data),
    .frame_valid (w_frame_valid),
    .frame_data  (w_frame_data),
    .rx_timeout  (w_rx_timeout)
  );

  // Write completes on the busy high-then-low sequence, read on the data strobe
  assign w_mem_expired = (r_mem_cnt == C_MEM_LAST);
  assign w_mem_done    = (r_cmd == C_CMD_WRITE) ? (r_busy_seen && !mem_busy) : mem_rd_rdy;

  assign tx_data  = r_reply[31:24];
  assign dbg_addr = mem_addr[4:0];

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_frame_valid) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_next_state = is_mem_cmd(r_cmd) ? S_MEM_WAIT_IDLE : S_TX_START;
      end
      S_MEM_WAIT_IDLE: begin
        if (!mem_busy)          w_next_state = S_MEM_REQ;
        else if (w_mem_expired) w_next_state = S_TX_START;
      end
      S_MEM_REQ: begin
        w_next_state = S_MEM_WAIT_DONE;
      end
      S_MEM_WAIT_DONE: begin
        if (w_mem_done || w_mem_expired) w_next_state = S_TX_START;
      end
      S_TX_START: begin
        if (tx_ready) w_next_state = S_TX_WAIT_LOW;
      end
      S_TX_WAIT_LOW: begin
        if (!tx_ready) w_next_state = S_TX_WAIT_HIGH;
      end
      S_TX_WAIT_HIGH: begin
        if (tx_ready) w_next_state = (r_tx_idx == 2'd3) ? S_IDLE : S_TX_START;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM strobe outputs, each a single cycle wide by construction
  always_comb begin
    tx_start   = 1'b0;
    mem_wr_req = 1'b0;
    mem_rd_req = 1'b0;
    case (r_state)
      S_TX_START: tx_start = tx_ready;
      S_MEM_REQ: begin
        mem_wr_req = (r_cmd == C_CMD_WRITE);
        mem_rd_req = (r_cmd == C_CMD_READ_REQ);
      end
      default: ;
    endcase
  end

  // Command datapath: frame capture, register commands, memory completion, reply shifting
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmd       <= 8'd0;
      r_arg       <= 32'd0;
      r_reply     <= 32'd0;
      r_tx_idx    <= 2'd0;
      r_mem_cnt   <= '0;
      r_busy_seen <= 1'b0;
      r_rd_latch  <= 32'd0;
      r_count     <= 32'd0;
      mem_addr    <= 32'd0;
      mem_wr_d    <= 32'd0;
      err_flags   <= 3'd0;
    end else begin
      if (w_rx_timeout) err_flags[C_ERR_RX_TO] <= 1'b1;
      if (w_frame_valid && (r_state != S_IDLE)) err_flags[C_ERR_DROP] <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_frame_valid) begin
            r_cmd <= w_frame_data[39:32];
            r_arg <= w_frame_data[31:0];
          end
        end
        S_DECODE: begin
          r_tx_idx    <= 2'd0;
          r_mem_cnt   <= '0;
          r_busy_seen <= 1'b0;
          case (r_cmd)
            C_CMD_ADDR: begin
              mem_addr <= r_arg;
              r_reply  <= r_arg;
            end
            C_CMD_LOAD: begin
              mem_wr_d <= r_arg;
              r_reply  <= r_arg;
            end
            C_CMD_READ:  r_reply <= r_rd_latch;
            C_CMD_COUNT: begin
              r_reply <= r_count;
              r_count <= r_count + 32'd1;
            end
            C_CMD_CONST:    r_reply <= CONST_VAL;
            C_CMD_WRITE,
            C_CMD_READ_REQ: r_reply <= 32'd0;
            default:        r_reply <= C_REPLY_BAD;
          endcase
        end
        S_MEM_WAIT_IDLE: begin
          r_mem_cnt <= r_mem_cnt + 1'b1;
          if (mem_busy && w_mem_expired) begin
            r_reply                 <= C_REPLY_MEM_TO;
            err_flags[C_ERR_MEM_TO] <= 1'b1;
          end
        end
        S_MEM_REQ: begin
          r_mem_cnt <= r_mem_cnt + 1'b1;
        end
        S_MEM_WAIT_DONE: begin
          r_mem_cnt <= r_mem_cnt + 1'b1;
          if (mem_busy) r_busy_seen <= 1'b1;
          if (w_mem_done) begin
            if (r_cmd == C_CMD_WRITE) begin
              r_reply <= C_REPLY_WR_OK;
            end else begin
              r_rd_latch <= mem_rd_d;
              r_reply    <= mem_rd_d;
            end
          end else if (w_mem_expired) begin
            r_reply                 <= C_REPLY_MEM_TO;
            err_flags[C_ERR_MEM_TO] <= 1'b1;
          end
        end
        S_TX_WAIT_HIGH: begin
          if (tx_ready) begin
            r_reply  <= {r_reply[23:0], 8'd0};
            r_tx_idx <= r_tx_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_engine
// Purpose  : Directed scoreboard bench for uart_cmd_engine with simple
//            uart_tx and hyper_xface behavioural models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_engine;

  localparam int RXT = 100;
  localparam int MT  = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_rcv = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_ready = 1'b1;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_d;
  logic        mem_wr_req;
  logic        mem_rd_req;
  logic        mem_busy;
  logic [31:0] mem_rd_d = 32'd0;
  logic        mem_rd_rdy = 1'b0;
  logic [4:0]  dbg_addr;
  logic [2:0]  err_flags;

  logic        busy_model = 1'b0;
  logic        busy_stuck = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          tx_cnt = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          tx_cnt_at_fall = -1;
  logic [31:0] wr_data = 32'd0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  assign mem_busy = busy_model | busy_stuck;

  uart_cmd_engine #(
    .RX_TIMEOUT  (RXT),
    .MEM_TIMEOUT (MT),
    .CONST_VAL   (32'd259)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_rcv     (rx_rcv),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .mem_addr   (mem_addr),
    .mem_wr_d   (mem_wr_d),
    .mem_wr_req (mem_wr_req),
    .mem_rd_req (mem_rd_req),
    .mem_busy   (mem_busy),
    .mem_rd_d   (mem_rd_d),
    .mem_rd_rdy (mem_rd_rdy),
    .dbg_addr   (dbg_addr),
    .err_flags  (err_flags)
  );

  // uart_tx model: ready drops two cycles after a start and returns ten cycles later
  int   tx_tick = 0;
  logic st_s;
  always begin
    @(posedge clk);
    st_s = tx_start;
    #1;
    if (st_s) begin
      tx_tick = 1;
    end else if (tx_tick > 0) begin
      tx_tick++;
      if (tx_tick == 3) tx_ready = 1'b0;
      if (tx_tick == 13) begin
        tx_ready = 1'b1;
        tx_tick  = 0;
      end
    end
  end

  // hyper_xface model: busy 1 cycle after a write for 20 cycles, read data 30 cycles after a read
  int          busy_timer = 0;
  int          rd_timer = 0;
  logic        wr_s, rd_s;
  logic [31:0] wd_s;
  always begin
    @(posedge clk);
    wr_s = mem_wr_req;
    rd_s = mem_rd_req;
    wd_s = mem_wr_d;
    #1;
    mem_rd_rdy = 1'b0;
    mem_rd_d   = 32'd0;
    if (wr_s) begin
      wr_cnt++;
      wr_data    = wd_s;
      busy_model = 1'b1;
      busy_timer = 20;
    end else if (busy_timer > 0) begin
      busy_timer--;
      if (busy_timer == 0) begin
        busy_model     = 1'b0;
        tx_cnt_at_fall = tx_cnt;
      end
    end
    if (rd_s) begin
      rd_cnt++;
      rd_timer = 30;
    end else if (rd_timer > 0) begin
      rd_timer--;
      if (rd_timer == 0) begin
        mem_rd_rdy = 1'b1;
        mem_rd_d   = 32'h1234_5678;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rcv  = 1'b1;
    @(negedge clk);
    rx_rcv  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] arg);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(arg[8*i +: 8]);
  endtask

  task automatic push_reply(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_tx_after(input int t0, input string name);
    int n;
    n = 0;
    while (tx_cnt == t0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, (tx_cnt != t0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wr_d"}, mem_wr_d, 0);
    chk({tag, "_mem_reqs"}, {mem_wr_req, mem_rd_req}, 0);
    chk({tag, "_dbg_addr"}, dbg_addr, 0);
    chk({tag, "_err_flags"}, err_flags, 0);
  endtask

  initial begin
    int t0, t1, w0, r0;
    fork
      // Scoreboard monitor: every tx_start pops and compares one expected byte
      forever begin
        @(negedge clk);
        if (rstn && tx_start) begin
          tx_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected actual=%h required=none", tx_data);
          end else begin
            logic [7:0] b;
            b = exp_q.pop_front();
            if (tx_data !== b) begin
              errors++;
              $display("FAIL tx_byte actual=%h required=%h", tx_data, b);
            end
          end
        end
      end
      begin
        // Reset state
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // ADDR
        t0 = tx_cnt;
        push_reply(32'h0000_000A);
        send_frame(8'h01, 32'h0000_000A);
        wait_drain("addr_drain");
        chk("addr_mem_addr", mem_addr, 32'h0000_000A);
        chk("addr_dbg_addr", dbg_addr, 5'h0A);
        chk("addr_tx_pulses", tx_cnt - t0, 4);

        // LOAD then WRITE
        push_reply(32'hDEAD_BEEF);
        send_frame(8'h02, 32'hDEAD_BEEF);
        wait_drain("load_drain");
        chk("load_mem_wr_d", mem_wr_d, 32'hDEAD_BEEF);
        w0 = wr_cnt;
        t0 = tx_cnt;
        push_reply(32'h0000_0003);
        send_frame(8'h03, 32'h0);
        wait_drain("write_drain");
        chk("write_req_pulses", wr_cnt - w0, 1);
        chk("write_data", wr_data, 32'hDEAD_BEEF);
        chk("write_reply_after_busy", tx_cnt_at_fall, t0);

        // READ_REQ then READ
        r0 = rd_cnt;
        push_reply(32'h1234_5678);
        send_frame(8'h05, 32'hA5A5_A5A5);
        wait_drain("rdreq_drain");
        chk("rdreq_req_pulses", rd_cnt - r0, 1);
        push_reply(32'h1234_5678);
        send_frame(8'h04, 32'h0);
        wait_drain("read_drain");

        // Partial frame timeout, then COUNT twice
        send_byte(8'h06);
        send_byte(8'h00);
        repeat (2 * RXT) @(negedge clk);
        chk("rx_timeout_flag", err_flags[0], 1);
        push_reply(32'h0000_0000);
        send_frame(8'h06, 32'h0);
        wait_drain("count0_drain");
        push_reply(32'h0000_0001);
        send_frame(8'h06, 32'h0);
        wait_drain("count1_drain");

        // Memory timeout with busy stuck high
        busy_stuck = 1'b1;
        w0 = wr_cnt;
        push_reply(32'hFFFF_FFFE);
        send_frame(8'h03, 32'h0);
        wait_drain("memto_drain");
        chk("memto_flag", err_flags[1], 1);
        chk("memto_no_req", wr_cnt - w0, 0);
        busy_stuck = 1'b0;
        repeat (5) @(negedge clk);

        // Second frame arriving during the first reply is dropped
        t0 = tx_cnt;
        push_reply(32'h0000_0103);
        send_frame(8'h07, 32'h0);
        wait_tx_after(t0, "drop_first_tx");
        send_frame(8'h07, 32'h0);
        wait_drain("drop_drain");
        repeat (100) @(negedge clk);
        chk("drop_flag", err_flags[2], 1);
        chk("drop_single_reply", tx_cnt - t0, 4);

        // Unknown command
        push_reply(32'hFFFF_FFFF);
        send_frame(8'h09, 32'h1122_3344);
        wait_drain("badcmd_drain");

        // Reset during TX_WAIT_HIGH of the first reply byte
        t0 = tx_cnt;
        exp_q.push_back(8'h00);
        send_frame(8'h07, 32'h0);
        wait_tx_after(t0, "rst_first_tx");
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_zero_outputs("midrst");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        t1 = tx_cnt;
        repeat (150) @(negedge clk);
        chk("midrst_no_more_tx", tx_cnt, t1);
        chk("midrst_queue", exp_q.size(), 0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_engine.md
Name: uart_cmd_engine

Overview:
- Command engine between `uart_rx`/`uart_tx` and `hyper_xface`.
- Assembles 5-byte serial frames: 1 command byte, then a 32-bit big-endian argument.
- Executes each frame as a register update or a HyperRAM read/write request, waiting for completion with a timeout.
- Returns exactly one 4-byte big-endian reply per accepted frame through a proper `uart_tx` handshake.

Parameters:
- RX_TIMEOUT, 1200000, idle clocks between bytes of a partial frame before the frame is discarded (100 ms at 12 MHz).
- MEM_TIMEOUT, 4096, max clocks for a memory operation (wait-idle plus wait-done, one shared counter).
- CONST_VAL, 32'd259, reply for the CONST command.

Ports:
- clk  in  1  system clock (hram_clk domain)
- rstn  in  1  asynchronous active-low reset
- rx_rcv  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_ready  in  1  uart_tx idle
- tx_start  out  1  one-cycle start strobe to uart_tx
- tx_data  out  8  byte to send, stable while tx_start is high
- mem_addr  out  32  address to hyper_xface
- mem_wr_d  out  32  write data to hyper_xface
- mem_wr_req  out  1  one-cycle write request
- mem_rd_req  out  1  one-cycle read request
- mem_busy  in  1  hyper_xface busy
- mem_rd_d  in  32  read data
- mem_rd_rdy  in  1  read data valid strobe
- dbg_addr  out  5  mem_addr[4:0] for LEDs
- err_flags  out  3  sticky flags: {frame_dropped, mem_timeout, rx_timeout}

Behaviour:
- Reset values:
  - all outputs 0; byte counter 0; FSM IDLE.
  - rd_latch 0; count 0; err_flags 0.
- Assembler:
  - On rx_rcv, shift rx_data into a 40-bit register; byte counter increments.
  - The 5th byte completes the frame: counter returns to 0 in the same cycle, and frame_valid pulses the next cycle.
- Partial-frame timeout:
  - Counter != 0 and RX_TIMEOUT clocks pass with no rx_rcv: counter cleared, err_flags[0] set.
  - The timer restarts on every rx_rcv.
- Frame dropping:
  - frame_valid while FSM != IDLE: frame dropped, err_flags[2] set, no reply.
  - The assembler always runs, independent of FSM state.
- Commands (cmd byte):
  - 0x01 ADDR: mem_addr <= arg; reply arg.
  - 0x02 LOAD: mem_wr_d <= arg; reply arg.
  - 0x03 WRITE: memory write; reply 0x00000003 on success.
  - 0x04 READ: reply rd_latch.
  - 0x05 READ_REQ: memory read; rd_latch <= mem_rd_d on mem_rd_rdy; reply the read data.
  - 0x06 COUNT: reply count, then count <= count+1 (wraps at 2^32).
  - 0x07 CONST: reply CONST_VAL.
  - Any other value: reply 0xFFFFFFFF, no side effects.
- FSM states: IDLE, DECODE, MEM_WAIT_IDLE, MEM_REQ, MEM_WAIT_DONE, TX_START, TX_WAIT_LOW, TX_WAIT_HIGH.
  - IDLE -> DECODE on frame_valid.
  - DECODE: register commands load the reply and go to TX_START; WRITE/READ_REQ go to MEM_WAIT_IDLE.
  - MEM_WAIT_IDLE: wait for !mem_busy, then go to MEM_REQ.
  - MEM_REQ: assert exactly one req for 1 cycle, then go to MEM_WAIT_DONE.
  - MEM_WAIT_DONE, write: complete on mem_busy seen high and then low.
  - MEM_WAIT_DONE, read: complete on mem_rd_rdy.
  - Memory timeout: the MEM_TIMEOUT counter is shared by MEM_WAIT_IDLE and MEM_WAIT_DONE. On expiry: reply 0xFFFFFFFE, err_flags[1] set, no request issued if still waiting for idle.
- Transmit, 4 bytes MSB first, with a byte index counter:
  - TX_START: when tx_ready, pulse tx_start with tx_data = reply[31:24] of the current shifted reply.
  - TX_WAIT_LOW: wait for tx_ready low (the 2-cycle uart_tx latency is tolerated).
  - TX_WAIT_HIGH: wait for tx_ready high, shift the reply left by 8, then return to TX_START, or to IDLE after the 4th byte.
- Reset mid-operation: asynchronous return to the reset values; an in-flight memory request is abandoned; no further tx_start is issued.
- Concurrency: rx_rcv arriving in the same cycle as the assembler timeout expiry counts as activity, so no timeout is taken.

Decomposition:
- Package uart_cmd_pkg holds:
  - command code localparams 0x01–0x07;
  - reply codes 0xFFFFFFFF (bad command) and 0xFFFFFFFE (memory timeout);
  - the FSM state enum;
  - the err_flags bit indices.
- Sub-module uart_frame_asm: byte counter, 40-bit shift register, RX timeout, frame_valid output.

Test Plan:
- Frame 01 00 00 00 0A -> mem_addr=0x0000000A; dbg_addr=5'h0A; UART out 00 00 00 0A; exactly 4 tx_start pulses.
- 02 DE AD BE EF, then 03 00 00 00 00, with busy modelled 1 cycle after req for 20 cycles -> one mem_wr_req pulse with mem_wr_d=0xDEADBEEF; reply 00 00 00 03 only after busy falls.
- 05 xx xx xx xx with mem_rd_d=0x12345678 and rd_rdy 30 cycles after req -> reply 12 34 56 78; a following 04 frame also replies 12 34 56 78.
- Two bytes 06 00, then silence beyond RX_TIMEOUT (set to 100), then 06 00 00 00 00 -> err_flags[0]=1; single reply 00 00 00 00; the next COUNT frame replies 00 00 00 01.
- mem_busy held high, then WRITE -> after MEM_TIMEOUT (set to 64) clocks: reply FF FF FF FE; err_flags[1]=1; no mem_wr_req pulse.
- 2nd frame sent back-to-back during the 1st reply -> 2nd frame dropped; err_flags[2]=1. Frame 0x09 -> reply FF FF FF FF. rstn asserted during TX_WAIT_HIGH -> outputs are 0 immediately.
